// File: rtl/nibble_add_sequencer_pkg.sv
// rtl/nibble_add_sequencer_pkg.sv - shared state encoding and default width for the nibble add sequencer
//
// Purpose: common definitions imported by the sequencer top and its result register.
//   state_t        FSM state encoding (S_A, S_B, S_ADD, S_HOLD)
//   DEFAULT_WIDTH  default operand/sum width, matching the attached 4-bit adder
package nibble_add_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_ADD  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_result_reg.sv
// rtl/nibble_result_reg.sv - captured sum/carry/zero with valid/ready hand-off
//
// Purpose: latches the adder result on a capture strobe and holds it until downstream accepts.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   capture                   load strobe (one cycle, from the sequencer's settle state)
//   sum_in, carry_in          adder outputs to capture
//   res_ready                 downstream accept
//   res_sum, res_carry        captured result
//   res_zero                  captured sum and carry both zero
//   res_valid                 result pending; cleared on res_valid & res_ready
module nibble_result_reg
  import nibble_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_valid <= 1'b0;
    end else if (capture) begin
      res_sum   <= sum_in;
      res_carry <= carry_in;
      res_zero  <= (sum_in == '0) && !carry_in;
      res_valid <= 1'b1;
    end else if (res_valid && res_ready) begin
      // Data fields stay as they were; only the valid flag drops.
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - operand sequencer and result capture around an external ripple adder
//
// Purpose: takes A then B over one valid/ready bus, drives them to the adder, captures the
// result one settle cycle later and offers it downstream. Accumulate mode reuses the last sum as A.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_data/in_valid/in_ready   operand input stream
//   acc_en                      sampled in S_A: reuse last sum as A
//   add_a, add_b                registered operands to the adder
//   add_sum, add_carry          combinational adder result
//   res_sum/res_carry/res_zero  captured result, res_valid/res_ready hand-off
//   ovf_sticky, ovf_clr         sticky carry flag and its synchronous clear
//   busy                        sequencer not idle in S_A
module nibble_add_sequencer
  import nibble_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_carry,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] last_sum;
  logic             load_a_in, load_a_acc, load_b, capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    load_a_in  = 1'b0;
    load_a_acc = 1'b0;
    load_b     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_A: begin
        in_ready = 1'b1;
        // Accumulate takes priority: A comes from last_sum and no input beat is consumed.
        if (acc_en) begin
          load_a_acc = 1'b1;
          state_nxt  = S_B;
        end else if (in_valid) begin
          load_a_in = 1'b1;
          state_nxt = S_B;
        end
      end
      S_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_b    = 1'b1;
          state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        // Operands have been stable at the adder for a full cycle; capture at this edge.
        capture   = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (res_valid && res_ready) state_nxt = S_A;
      end
      default: state_nxt = S_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a      <= '0;
      add_b      <= '0;
      last_sum   <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (load_a_acc)     add_a <= last_sum;
      else if (load_a_in) add_a <= in_data;
      if (load_b)         add_b <= in_data;
      if (capture)        last_sum <= add_sum;
      // A carry captured in the same cycle as a clear keeps the flag set.
      if (capture && add_carry) ovf_sticky <= 1'b1;
      else if (ovf_clr)         ovf_sticky <= 1'b0;
    end
  end

  assign busy = (state != S_A);

  nibble_result_reg #(.WIDTH(WIDTH)) u_result (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .sum_in   (add_sum),
    .carry_in (add_carry),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_carry(res_carry),
    .res_zero (res_zero),
    .res_valid(res_valid)
  );

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - self-checking bench for nibble_add_sequencer
module tb_nibble_add_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       acc_en;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_carry;
  logic [3:0] res_sum;
  logic       res_carry, res_zero, res_valid, res_ready;
  logic       ovf_sticky, ovf_clr, busy;

  int checks = 0;
  int errors = 0;

  // Reference state: last captured sum and sticky overflow, from the arithmetic rules.
  int m_last = 0;
  bit m_ovf  = 1'b0;

  always #5 clk = ~clk;

  // External 4-bit adder.
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  nibble_add_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .acc_en(acc_en),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_carry(add_carry),
    .res_sum(res_sum), .res_carry(res_carry), .res_zero(res_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: load A (or accumulate), load B, settle, hold, release.
  task automatic do_op(input bit acc, input logic [3:0] a, input logic [3:0] b, input int hold,
                       input bit clr_add, output logic [3:0] o_sum, output logic o_carry,
                       output logic o_zero, output logic o_ovf);
    int ea, tot, es;
    bit ec;
    ea  = acc ? m_last : int'(a);
    tot = ea + int'(b);
    es  = tot % 16;
    ec  = (tot > 15);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    if (acc) begin
      acc_en = 1'b1; in_valid = 1'b0; in_data = ~a;
    end else begin
      acc_en = 1'b0; in_valid = 1'b1; in_data = a;
    end
    tick();
    acc_en = 1'b0;
    chk("add_a", add_a, ea);
    chk("b_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0;
    chk("add_b", add_b, b);
    chk("settle_in_ready", in_ready, 0);
    chk("settle_res_valid", res_valid, 0);
    ovf_clr = clr_add;
    tick();
    ovf_clr = 1'b0;
    if (ec) m_ovf = 1'b1;
    else if (clr_add) m_ovf = 1'b0;
    chk("res_valid", res_valid, 1);
    chk("res_sum", res_sum, es);
    chk("res_carry", res_carry, ec);
    chk("res_zero", res_zero, (es == 0) && !ec);
    chk("ovf_sticky", ovf_sticky, m_ovf);
    o_sum = res_sum; o_carry = res_carry; o_zero = res_zero; o_ovf = ovf_sticky;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 4'($urandom);
      tick();
      chk("hold_in_ready", in_ready, 0);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_sum", res_sum, es);
      chk("hold_res_carry", res_carry, ec);
      chk("hold_add_b", add_b, b);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("release_res_valid", res_valid, 0);
    chk("release_busy", busy, 0);
    m_last = es;
  endtask

  typedef struct {
    bit         acc;
    logic [3:0] a, b;
    int         hold;
    bit         clr_add;
    bit         clr_after;
    logic [3:0] sum;
    bit         carry, zero, ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [3:0] s;
    logic       c, z, o;

    vecs[0] = '{acc:0, a:3,  b:4,  hold:0, clr_add:0, clr_after:0, sum:7,  carry:0, zero:0, ovf:0};
    vecs[1] = '{acc:0, a:9,  b:7,  hold:0, clr_add:0, clr_after:1, sum:0,  carry:1, zero:0, ovf:1};
    vecs[2] = '{acc:0, a:0,  b:0,  hold:5, clr_add:0, clr_after:0, sum:0,  carry:0, zero:1, ovf:0};
    vecs[3] = '{acc:0, a:5,  b:6,  hold:0, clr_add:0, clr_after:0, sum:11, carry:0, zero:0, ovf:0};
    vecs[4] = '{acc:1, a:0,  b:7,  hold:1, clr_add:1, clr_after:0, sum:2,  carry:1, zero:0, ovf:1};
    vecs[5] = '{acc:0, a:15, b:15, hold:2, clr_add:0, clr_after:0, sum:14, carry:1, zero:0, ovf:1};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; acc_en = 1'b0; res_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_zero", res_zero, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_add_a", add_a, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].acc, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].clr_add, s, c, z, o);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      chk($sformatf("vec%0d_carry", i), c, vecs[i].carry);
      chk($sformatf("vec%0d_zero", i), z, vecs[i].zero);
      chk($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
      if (vecs[i].clr_after) begin
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        chk($sformatf("vec%0d_ovf_clr", i), ovf_sticky, 0);
      end
    end

    for (int r = 0; r < 40; r++) begin
      do_op(($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0), s, c, z, o);
    end

    // Reset while the adder result is settling: the pending result must be dropped.
    in_valid = 1'b1; in_data = 4'd1;
    tick();
    in_data = 4'd1;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_add_a", add_a, 0);
    chk("midrst_add_b", add_b, 0);
    chk("midrst_ovf", ovf_sticky, 0);
    tick();
    rst = 1'b0;
    m_last = 0;
    m_ovf  = 1'b0;
    tick();
    chk("postrst_res_valid", res_valid, 0);
    do_op(1'b0, 4'd1, 4'd1, 0, 1'b0, s, c, z, o);
    chk("postrst_1p1", s, 2);
    // Accumulate after reset starts from the fresh sum, not anything before reset.
    do_op(1'b1, 4'd0, 4'd5, 0, 1'b0, s, c, z, o);
    chk("postrst_acc", s, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
